// File: rtl/sid_pkg.sv
// Shared widths, saturation limits and the 18-bit-to-16-bit saturator used by
// the SID filter multiplier and the integrator clippers.
`timescale 1ns/1ps
package sid_pkg;

   localparam int SAMPLE_W = 16;
   localparam int ACC_W    = 17;
   localparam int COEF_W   = 16;

   localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
   localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

   // Saturate an 18-bit signed value to 16 bits. The value fits when its top
   // three bits all agree; otherwise the sign bit picks the rail.
   function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [17:0] x);
      logic signed [SAMPLE_W-1:0] r;
      if ((x[17:15] == 3'b000) || (x[17:15] == 3'b111)) begin
         r = x[15:0];
      end else if (x[17]) begin
         r = SAT_MIN;
      end else begin
         r = SAT_MAX;
      end
      return r;
   endfunction

endpackage

// File: rtl/sid_filter_mult_clip_if.sv
// Bus between the filter state machine / mixer and the arithmetic datapath.
// Handshake: iValid is a pure tag that travels with iSignal/iCoef; there is no
// ready and no back-pressure. The datapath samples operands every cycle and
// returns oValid aligned with oOut exactly two cycles later.
`timescale 1ns/1ps
interface sid_filter_mult_clip_if;
   import sid_pkg::*;

   logic signed [ACC_W-1:0]    iSignal;
   logic        [COEF_W-1:0]   iCoef;
   logic                       iValid;
   logic signed [SAMPLE_W-1:0] oOut;
   logic                       oValid;

   logic signed [ACC_W-1:0]    iLow;
   logic signed [ACC_W-1:0]    iBand;
   logic signed [ACC_W-1:0]    iHigh;
   logic signed [SAMPLE_W-1:0] oLP;
   logic signed [SAMPLE_W-1:0] oBP;
   logic signed [SAMPLE_W-1:0] oHP;

   // Filter side: supplies operands and integrator states.
   modport master (
      output iSignal, iCoef, iValid, iLow, iBand, iHigh,
      input  oOut, oValid, oLP, oBP, oHP
   );

   // Datapath side.
   modport slave (
      input  iSignal, iCoef, iValid, iLow, iBand, iHigh,
      output oOut, oValid, oLP, oBP, oHP
   );

endinterface

// File: rtl/sid_filter_mult_clip_clipper.sv
// Combinational 17-bit to 16-bit saturator for one integrator state.
`timescale 1ns/1ps
module clipper
   import sid_pkg::*;
(
   input  logic signed [ACC_W-1:0]    din,
   output logic signed [SAMPLE_W-1:0] dout
);

   // Sign-extend to the saturator width and clamp.
   always_comb begin
      dout = sat16({din[ACC_W-1], din});
   end

endmodule

// File: rtl/sid_filter_mult_clip_mult.sv
// Two-stage signed(17) x unsigned(16) coefficient multiplier. Stage 1 holds
// the operands, stage 2 holds the scaled, saturated product. The shape maps
// onto a DSP block with input and output registers.
`timescale 1ns/1ps
module mult16x16
   import sid_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [ACC_W-1:0]    sig,
   input  logic        [COEF_W-1:0]   coef,
   output logic signed [SAMPLE_W-1:0] result
);

   logic signed [ACC_W-1:0]  sig_q;
   logic        [COEF_W-1:0] coef_q;
   logic signed [33:0]       product;
   logic signed [17:0]       scaled;
   logic                     unused_frac;

   // Stage 1: capture operands.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q  <= '0;
         coef_q <= '0;
      end else begin
         sig_q  <= sig;
         coef_q <= coef;
      end
   end

   // Exact 34-bit product; taking bits [33:16] is an arithmetic shift by 16,
   // which floors toward minus infinity.
   always_comb begin
      product     = $signed({{17{sig_q[ACC_W-1]}}, sig_q}) * $signed({18'd0, coef_q});
      scaled      = product[33:16];
      unused_frac = ^product[15:0];
   end

   // Stage 2: register the saturated result.
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
      end else begin
         result <= sat16(scaled);
      end
   end

endmodule

// File: rtl/sid_filter_mult_clip.sv
// SID filter arithmetic datapath: coefficient multiplier with a valid tag
// pipeline matched to its two-cycle latency, plus three output clippers.
`timescale 1ns/1ps
module sid_filter_mult_clip
   import sid_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   sid_filter_mult_clip_if.slave  bus
);

   logic [1:0] valid_q;

   mult16x16 u_mult (
      .clk    (clk),
      .rst    (rst),
      .sig    (bus.iSignal),
      .coef   (bus.iCoef),
      .result (bus.oOut)
   );

   // Valid tag follows the operands through both multiplier stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 2'b00;
      end else begin
         valid_q <= {valid_q[0], bus.iValid};
      end
   end

   assign bus.oValid = valid_q[1];

   clipper u_lp (.din(bus.iLow),  .dout(bus.oLP));
   clipper u_bp (.din(bus.iBand), .dout(bus.oBP));
   clipper u_hp (.din(bus.iHigh), .dout(bus.oHP));

endmodule

// File: tb/tb_sid_filter_mult_clip.sv
// Self-checking bench for sid_filter_mult_clip: directed plan cases followed
// by randomized traffic, against an arithmetic reference model.
`timescale 1ns/1ps
module tb_sid_filter_mult_clip;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   // Expected {valid, out} entries still travelling through the datapath.
   logic [16:0] exp_q[$];

   sid_filter_mult_clip_if bus ();

   sid_filter_mult_clip dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int clamp16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   // floor(sig * coef / 65536), saturated.
   function automatic int model_mult(input int sig, input int coef);
      longint p;
      longint q;
      p = longint'(sig) * longint'(coef);
      q = p / 65536;
      if ((p < 0) && ((p % 65536) != 0)) q = q - 1;
      return clamp16(q);
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Drive one cycle of inputs, check clippers combinationally, then advance
   // one clock and check the multiplier output against the model.
   task automatic step(input int sig, input int coef, input bit vld, input bit r,
                       input int lo, input int bd, input int hi);
      logic [16:0] e;
      int          e_out;
      bus.iSignal = 17'(sig);
      bus.iCoef   = 16'(coef);
      bus.iValid  = vld;
      bus.iLow    = 17'(lo);
      bus.iBand   = 17'(bd);
      bus.iHigh   = 17'(hi);
      rst         = r;
      #1;
      check("clip_lp", int'(bus.oLP), clamp16(longint'(lo)));
      check("clip_bp", int'(bus.oBP), clamp16(longint'(bd)));
      check("clip_hp", int'(bus.oHP), clamp16(longint'(hi)));
      @(posedge clk);
      if (r) begin
         e = '0;
         exp_q.delete();
         exp_q.push_back('0);
      end else begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'd0;
         exp_q.push_back({vld, 16'(model_mult(sig, coef))});
      end
      #1;
      e_out = int'($signed(e[15:0]));
      check("mult_out",   int'(bus.oOut),  e_out);
      check("mult_valid", int'(bus.oValid), int'(e[16]));
   endtask

   task automatic mstep(input int sig, input int coef, input bit vld, input bit r);
      step(sig, coef, vld, r, 0, 0, 0);
   endtask

   function automatic int rand_acc();
      case ($urandom_range(0, 5))
         0: return 65535;
         1: return -65536;
         2: return int'($urandom_range(32760, 32775)) * ((($urandom_range(0, 1)) != 0) ? 1 : -1);
         default: return int'($urandom_range(0, 131071)) - 65536;
      endcase
   endfunction

   function automatic int rand_coef();
      case ($urandom_range(0, 5))
         0: return 0;
         1: return 1;
         2: return 32'h8000;
         3: return 32'hFFFF;
         default: return int'($urandom_range(0, 65535));
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      n_checks = 0;
      n_errors = 0;
      @(posedge clk);
      #1;

      // Reset held 3 cycles with live operands: nothing may come out.
      repeat (3) step(1000, 32'h8000, 1'b1, 1'b1, 0, 0, 0);
      mstep(1000, 32'h8000, 1'b1, 1'b0);
      mstep(0, 0, 1'b0, 1'b0);
      check("post_reset_500", int'(bus.oOut), 500);
      check("post_reset_vld", int'(bus.oValid), 1);

      // Scaling, rounding and saturation corner cases.
      mstep(1000,   32'h8000, 1'b1, 1'b0);
      mstep(-1000,  32'h8000, 1'b1, 1'b0);
      mstep(-1,     32'h0001, 1'b1, 1'b0);
      mstep(32767,  32'hFFFF, 1'b1, 1'b0);
      mstep(-65536, 32'h0000, 1'b1, 1'b0);
      mstep(65535,  32'hFFFF, 1'b1, 1'b0);
      mstep(-65536, 32'hFFFF, 1'b1, 1'b0);
      mstep(-65536, 32'h8000, 1'b1, 1'b0);

      // Back-to-back stream with toggling valid.
      mstep(1000, 32'h8000, 1'b1, 1'b0);
      mstep(2000, 32'h8000, 1'b0, 1'b0);
      mstep(3000, 32'h8000, 1'b1, 1'b0);
      mstep(0, 0, 1'b0, 1'b0);
      mstep(0, 0, 1'b0, 1'b0);

      // Mid-stream reset drops the in-flight pair.
      mstep(1000, 32'h8000, 1'b1, 1'b0);
      mstep(2000, 32'h8000, 1'b1, 1'b1);
      mstep(3000, 32'h8000, 1'b1, 1'b0);
      mstep(0, 0, 1'b0, 1'b0);
      check("midrst_after", int'(bus.oOut), 1500);

      // Clipper boundaries, including while reset is asserted.
      step(0, 0, 1'b0, 1'b0, 40000,  -40000, 12345);
      step(0, 0, 1'b0, 1'b1, 32767,  -32768, 32768);
      step(0, 0, 1'b0, 1'b0, -32769, 65535,  -65536);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         step(rand_acc(), rand_coef(), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 29) == 0),
              rand_acc(), rand_acc(), rand_acc());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
